// File: rtl/spi_slave_port_pkg.sv
// Shared definitions for the SPI slave endpoint: frame width default and FSM encoding.
package spi_slave_port_pkg;

    localparam int unsigned DATA_N_DEFAULT      = 8;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one SPI pin with registered rise/fall pulses
// taken from the synchronised level and its one-cycle-delayed copy.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_sync <= '0;
            r_last <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_last <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_last;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_last;
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_slave_port.sv
// SPI slave endpoint on the system clock: oversampled pins, byte deserialiser
// into an rx holding register, and a single-entry tx buffer serialised on miso.
module spi_slave_port
    import spi_slave_port_pkg::*;
#(
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned DATA_N      = DATA_N_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cs,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_N-1:0] tx_data,
    input  logic              tx_we,
    output logic              tx_empty,
    output logic [DATA_N-1:0] rx_data,
    output logic              rx_full,
    input  logic              rx_rd,
    output logic              overrun,
    output logic              underrun
);

    localparam int unsigned CNT_W = $clog2(DATA_N);

    logic w_cs_s, w_cs_fall, w_unused_cs_rise;
    logic w_sck_rise, w_sck_fall, w_unused_sck_level;
    logic w_mosi_s, w_unused_mosi_rise, w_unused_mosi_fall;
    logic w_lead_edge, w_sample_edge, w_shift_edge;
    logic [DATA_N-1:0] w_load_val;

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_N-2:0] r_rx_sh;
    logic [DATA_N-1:0] r_tx_sh;
    logic [DATA_N-1:0] r_tx_buf;
    logic [DATA_N-1:0] r_rx_data;
    logic              r_tx_empty;
    logic              r_rx_full;
    logic              r_overrun;
    logic              r_underrun;
    logic              r_pend_under;
    logic              r_miso;
    logic              r_miso_oe;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .n_reset(n_reset), .i_pin(cs),
        .o_level(w_cs_s), .o_rise(w_unused_cs_rise), .o_fall(w_cs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .n_reset(n_reset), .i_pin(sck),
        .o_level(w_unused_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .n_reset(n_reset), .i_pin(mosi),
        .o_level(w_mosi_s), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
    );

    // Leading edge leaves the idle level; CPHA picks which edge samples.
    assign w_lead_edge   = (CPOL == 1'b1) ? w_sck_fall : w_sck_rise;
    assign w_sample_edge = (CPHA == 1'b1) ? (w_sck_rise ^ w_sck_fall) & ~w_lead_edge : w_lead_edge;
    assign w_shift_edge  = (CPHA == 1'b1) ? w_lead_edge : (w_sck_rise ^ w_sck_fall) & ~w_lead_edge;

    // A same-cycle tx_we bypasses the buffer; an empty buffer sends all ones.
    assign w_load_val = tx_we      ? tx_data :
                        r_tx_empty ? {DATA_N{1'b1}} : r_tx_buf;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_rx_sh      <= '0;
            r_tx_sh      <= '0;
            r_tx_buf     <= '0;
            r_rx_data    <= '0;
            r_tx_empty   <= 1'b1;
            r_rx_full    <= 1'b0;
            r_overrun    <= 1'b0;
            r_underrun   <= 1'b0;
            r_pend_under <= 1'b0;
            r_miso       <= 1'b1;
            r_miso_oe    <= 1'b0;
        end else begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
            if (rx_rd) begin
                r_rx_full <= 1'b0;
            end
            if (tx_we) begin
                r_tx_buf   <= tx_data;
                r_tx_empty <= 1'b0;
            end
            if (w_cs_s) begin
                r_state      <= ST_IDLE;
                r_bit_cnt    <= '0;
                r_miso       <= 1'b1;
                r_miso_oe    <= 1'b0;
                r_pend_under <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        r_tx_empty   <= 1'b1;
                        r_pend_under <= r_tx_empty & ~tx_we;
                        r_miso_oe    <= 1'b1;
                        r_state      <= ST_SHIFT;
                        if (CPHA == 1'b0) begin
                            r_miso  <= w_load_val[DATA_N-1];
                            r_tx_sh <= {w_load_val[DATA_N-2:0], 1'b0};
                        end else begin
                            r_tx_sh <= w_load_val;
                        end
                    end
                    ST_SHIFT: begin
                        if (w_sample_edge) begin
                            // Underrun is flagged once the dummy byte actually starts moving.
                            if (r_bit_cnt == '0) begin
                                r_underrun <= r_pend_under;
                            end
                            if (r_bit_cnt == CNT_W'(DATA_N - 1)) begin
                                r_rx_data <= {r_rx_sh, w_mosi_s};
                                r_rx_full <= 1'b1;
                                r_overrun <= r_rx_full & ~rx_rd;
                                r_bit_cnt <= '0;
                                r_state   <= ST_LOAD;
                            end else begin
                                r_rx_sh   <= {r_rx_sh[DATA_N-3:0], w_mosi_s};
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                        // In CPHA=0 the edge after the last sample must not disturb the reloaded MSB.
                        if (w_shift_edge && ((CPHA == 1'b1) || (r_bit_cnt != '0))) begin
                            r_miso  <= r_tx_sh[DATA_N-1];
                            r_tx_sh <= {r_tx_sh[DATA_N-2:0], 1'b0};
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign miso     = r_miso;
    assign miso_oe  = r_miso_oe;
    assign tx_empty = r_tx_empty;
    assign rx_data  = r_rx_data;
    assign rx_full  = r_rx_full;
    assign overrun  = r_overrun;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: port 0 is a mode-0 instance, port 1 a mode-3 instance,
// both driven by a bit-level SPI master and checked against a byte-level model.
module tb_spi_slave_port;

    localparam int HP = 8;

    logic clk = 1'b0;
    logic n_reset;
    logic [1:0] cs, sck, mosi, tx_we, rx_rd;
    logic [1:0][7:0] tx_data;
    logic [1:0] miso, miso_oe, tx_empty, rx_full, overrun, underrun;
    logic [1:0][7:0] rx_data;

    int vectors;
    int miscompares;
    int under_cnt [2];
    int over_cnt  [2];

    // Byte-level model of the slave's buffers and flags.
    logic       m_tx_full  [2];
    logic [7:0] m_tx_buf   [2];
    logic [7:0] m_cur_tx   [2];
    logic       m_cur_empty[2];
    logic       m_rx_full  [2];
    logic [7:0] m_rx_data  [2];
    int         m_under    [2];
    int         m_over     [2];

    always #5 clk = ~clk;

    spi_slave_port #(.CPOL(1'b0), .CPHA(1'b0), .DATA_N(8), .SYNC_STAGES(2)) u_mode0 (
        .clk(clk), .n_reset(n_reset), .cs(cs[0]), .sck(sck[0]), .mosi(mosi[0]),
        .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data[0]), .tx_we(tx_we[0]),
        .tx_empty(tx_empty[0]), .rx_data(rx_data[0]), .rx_full(rx_full[0]), .rx_rd(rx_rd[0]),
        .overrun(overrun[0]), .underrun(underrun[0])
    );

    spi_slave_port #(.CPOL(1'b1), .CPHA(1'b1), .DATA_N(8), .SYNC_STAGES(2)) u_mode3 (
        .clk(clk), .n_reset(n_reset), .cs(cs[1]), .sck(sck[1]), .mosi(mosi[1]),
        .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data[1]), .tx_we(tx_we[1]),
        .tx_empty(tx_empty[1]), .rx_data(rx_data[1]), .rx_full(rx_full[1]), .rx_rd(rx_rd[1]),
        .overrun(overrun[1]), .underrun(underrun[1])
    );

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (underrun[k] === 1'b1) under_cnt[k] = under_cnt[k] + 1;
            if (overrun[k] === 1'b1)  over_cnt[k]  = over_cnt[k] + 1;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_tx_full[k] = 1'b0; m_tx_buf[k] = 8'h00; m_cur_tx[k] = 8'hFF; m_cur_empty[k] = 1'b1;
            m_rx_full[k] = 1'b0; m_rx_data[k] = 8'h00;
        end
    endtask

    // A load takes the buffered byte (or a dummy 0xFF) and empties the buffer.
    task automatic model_load(input int p);
        m_cur_tx[p]    = m_tx_full[p] ? m_tx_buf[p] : 8'hFF;
        m_cur_empty[p] = !m_tx_full[p];
        m_tx_full[p]   = 1'b0;
    endtask

    task automatic do_tx_we(input int p, input logic [7:0] b);
        tx_data[p] = b; tx_we[p] = 1'b1;
        wait_clks(1);
        tx_we[p] = 1'b0;
        m_tx_buf[p] = b; m_tx_full[p] = 1'b1;
    endtask

    task automatic do_rx_rd(input int p);
        rx_rd[p] = 1'b1;
        wait_clks(1);
        rx_rd[p] = 1'b0;
        m_rx_full[p] = 1'b0;
    endtask

    task automatic frame_start(input int p);
        cs[p] = 1'b0;
        model_load(p);
        wait_clks(HP);
    endtask

    task automatic frame_end(input int p);
        wait_clks(HP);
        cs[p] = 1'b1;
        wait_clks(2 * HP);
    endtask

    // Bit-level master: port 0 samples on rising sck, port 1 (idle high) on rising/trailing.
    task automatic xfer(input int p, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (p == 0) begin
                mosi[p] = tx[i]; wait_clks(HP);
                rx[i] = miso[p]; sck[p] = 1'b1; wait_clks(HP);
                sck[p] = 1'b0;
            end else begin
                sck[p] = 1'b0; mosi[p] = tx[i]; wait_clks(HP);
                rx[i] = miso[p]; sck[p] = 1'b1; wait_clks(HP);
            end
        end
    endtask

    // Full byte plus the model's view: dummy-byte underrun, completion, reload.
    task automatic send_byte(input int p, input logic [7:0] b, output logic [7:0] got, output logic [7:0] exp);
        exp = m_cur_tx[p];
        if (m_cur_empty[p]) m_under[p] = m_under[p] + 1;
        xfer(p, b, 8, got);
        if (m_rx_full[p]) m_over[p] = m_over[p] + 1;
        m_rx_full[p] = 1'b1; m_rx_data[p] = b;
        model_load(p);
    endtask

    task automatic test_reset();
        for (int p = 0; p < 2; p++) begin
            vectors += 7;
            if (miso[p] !== 1'b1)         begin miscompares++; $display("FAIL reset_miso p%0d: got %b exp 1", p, miso[p]); end
            if (miso_oe[p] !== 1'b0)      begin miscompares++; $display("FAIL reset_miso_oe p%0d: got %b exp 0", p, miso_oe[p]); end
            if (tx_empty[p] !== 1'b1)     begin miscompares++; $display("FAIL reset_tx_empty p%0d: got %b exp 1", p, tx_empty[p]); end
            if (rx_data[p] !== 8'h00)     begin miscompares++; $display("FAIL reset_rx_data p%0d: got %h exp 00", p, rx_data[p]); end
            if (rx_full[p] !== 1'b0)      begin miscompares++; $display("FAIL reset_rx_full p%0d: got %b exp 0", p, rx_full[p]); end
            if (overrun[p] !== 1'b0)      begin miscompares++; $display("FAIL reset_overrun p%0d: got %b exp 0", p, overrun[p]); end
            if (underrun[p] !== 1'b0)     begin miscompares++; $display("FAIL reset_underrun p%0d: got %b exp 0", p, underrun[p]); end
        end
    endtask

    task automatic test_mode0_basic();
        logic [7:0] got, exp;
        do_tx_we(0, 8'h53);
        frame_start(0);
        vectors += 2;
        if (tx_empty[0] !== 1'b1) begin miscompares++; $display("FAIL m0_tx_empty_after_load: got %b exp 1", tx_empty[0]); end
        if (miso_oe[0] !== 1'b1)  begin miscompares++; $display("FAIL m0_miso_oe: got %b exp 1", miso_oe[0]); end
        send_byte(0, 8'hAC, got, exp);
        frame_end(0);
        vectors += 5;
        if (got !== 8'h53)           begin miscompares++; $display("FAIL m0_master_read: got %h exp 53", got); end
        if (rx_full[0] !== 1'b1)     begin miscompares++; $display("FAIL m0_rx_full: got %b exp 1", rx_full[0]); end
        if (rx_data[0] !== 8'hAC)    begin miscompares++; $display("FAIL m0_rx_data: got %h exp ac", rx_data[0]); end
        if (under_cnt[0] !== m_under[0]) begin miscompares++; $display("FAIL m0_underrun_cnt: got %0d exp %0d", under_cnt[0], m_under[0]); end
        if (miso_oe[0] !== 1'b0)     begin miscompares++; $display("FAIL m0_miso_oe_idle: got %b exp 0", miso_oe[0]); end
        do_rx_rd(0);
        vectors++;
        if (rx_full[0] !== 1'b0) begin miscompares++; $display("FAIL m0_rx_rd_clear: got %b exp 0", rx_full[0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got1, got2, exp;
        do_tx_we(1, 8'hF0);
        frame_start(1);
        do_tx_we(1, 8'h0F);
        send_byte(1, 8'hAC, got1, exp);
        vectors += 2;
        if (got1 !== 8'hF0)       begin miscompares++; $display("FAIL b2b_read1: got %h exp f0", got1); end
        if (rx_data[1] !== 8'hAC) begin miscompares++; $display("FAIL b2b_rx1: got %h exp ac", rx_data[1]); end
        do_rx_rd(1);
        send_byte(1, 8'h53, got2, exp);
        frame_end(1);
        vectors += 5;
        if (got2 !== 8'h0F)          begin miscompares++; $display("FAIL b2b_read2: got %h exp 0f", got2); end
        if (rx_data[1] !== 8'h53)    begin miscompares++; $display("FAIL b2b_rx2: got %h exp 53", rx_data[1]); end
        if (rx_full[1] !== 1'b1)     begin miscompares++; $display("FAIL b2b_rx_full: got %b exp 1", rx_full[1]); end
        if (over_cnt[1] !== 0)       begin miscompares++; $display("FAIL b2b_overrun: got %0d exp 0", over_cnt[1]); end
        if (under_cnt[1] !== m_under[1]) begin miscompares++; $display("FAIL b2b_underrun: got %0d exp %0d", under_cnt[1], m_under[1]); end
        do_rx_rd(1);
    endtask

    task automatic test_partial();
        logic [7:0] got, exp, b;
        int ov0;
        ov0 = over_cnt[0];
        b = 8'($urandom);
        do_tx_we(0, b);
        frame_start(0);
        xfer(0, 8'($urandom), 5, got);
        frame_end(0);
        vectors += 3;
        if (rx_full[0] !== 1'b0)  begin miscompares++; $display("FAIL partial_rx_full: got %b exp 0", rx_full[0]); end
        if (over_cnt[0] !== ov0)  begin miscompares++; $display("FAIL partial_overrun: got %0d exp %0d", over_cnt[0], ov0); end
        if (got[7:3] !== b[7:3])  begin miscompares++; $display("FAIL partial_read: got %h exp %h", got[7:3], b[7:3]); end
        b = 8'($urandom);
        do_tx_we(0, b);
        frame_start(0);
        send_byte(0, 8'h81, got, exp);
        frame_end(0);
        vectors += 3;
        if (rx_data[0] !== 8'h81) begin miscompares++; $display("FAIL partial_next_rx: got %h exp 81", rx_data[0]); end
        if (rx_full[0] !== 1'b1)  begin miscompares++; $display("FAIL partial_next_full: got %b exp 1", rx_full[0]); end
        if (got !== b)            begin miscompares++; $display("FAIL partial_next_read: got %h exp %h", got, b); end
        do_rx_rd(0);
    endtask

    task automatic test_underrun_overrun();
        logic [7:0] got, exp, a, b;
        int un0, ov0;
        un0 = under_cnt[0]; ov0 = over_cnt[0];
        a = 8'($urandom); b = 8'($urandom);
        frame_start(0);
        send_byte(0, a, got, exp);
        frame_end(0);
        vectors += 3;
        if (got !== 8'hFF)           begin miscompares++; $display("FAIL ur_read: got %h exp ff", got); end
        if (under_cnt[0] !== un0 + 1) begin miscompares++; $display("FAIL ur_count: got %0d exp %0d", under_cnt[0], un0 + 1); end
        if (rx_data[0] !== a)        begin miscompares++; $display("FAIL ur_rx: got %h exp %h", rx_data[0], a); end
        do_tx_we(0, 8'h66);
        frame_start(0);
        send_byte(0, b, got, exp);
        frame_end(0);
        vectors += 3;
        if (over_cnt[0] !== ov0 + 1) begin miscompares++; $display("FAIL ov_count: got %0d exp %0d", over_cnt[0], ov0 + 1); end
        if (rx_data[0] !== b)        begin miscompares++; $display("FAIL ov_rx: got %h exp %h", rx_data[0], b); end
        if (under_cnt[0] !== un0 + 1) begin miscompares++; $display("FAIL ov_no_underrun: got %0d exp %0d", under_cnt[0], un0 + 1); end
        do_rx_rd(0);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] got, exp;
        do_tx_we(0, 8'h5A);
        frame_start(0);
        xfer(0, 8'hE7, 3, got);
        n_reset = 1'b0;
        wait_clks(1);
        n_reset = 1'b1;
        model_reset();
        vectors += 6;
        if (miso[0] !== 1'b1)     begin miscompares++; $display("FAIL rst_mid_miso: got %b exp 1", miso[0]); end
        if (miso_oe[0] !== 1'b0)  begin miscompares++; $display("FAIL rst_mid_miso_oe: got %b exp 0", miso_oe[0]); end
        if (tx_empty[0] !== 1'b1) begin miscompares++; $display("FAIL rst_mid_tx_empty: got %b exp 1", tx_empty[0]); end
        if (rx_data[0] !== 8'h00) begin miscompares++; $display("FAIL rst_mid_rx_data: got %h exp 00", rx_data[0]); end
        if (rx_full[0] !== 1'b0)  begin miscompares++; $display("FAIL rst_mid_rx_full: got %b exp 0", rx_full[0]); end
        if (underrun[0] !== 1'b0) begin miscompares++; $display("FAIL rst_mid_underrun: got %b exp 0", underrun[0]); end
        cs[0] = 1'b1;
        wait_clks(2 * HP);
        do_tx_we(0, 8'hC3);
        frame_start(0);
        send_byte(0, 8'h3C, got, exp);
        frame_end(0);
        vectors += 3;
        if (rx_data[0] !== 8'h3C) begin miscompares++; $display("FAIL rst_next_rx: got %h exp 3c", rx_data[0]); end
        if (rx_full[0] !== 1'b1)  begin miscompares++; $display("FAIL rst_next_full: got %b exp 1", rx_full[0]); end
        if (got !== 8'hC3)        begin miscompares++; $display("FAIL rst_next_read: got %h exp c3", got); end
        do_rx_rd(0);
    endtask

    task automatic test_random();
        logic [7:0] got, exp;
        int p, nb;
        for (int it = 0; it < 12; it++) begin
            p  = int'($urandom_range(0, 1));
            nb = int'($urandom_range(1, 2));
            if ($urandom_range(0, 1) == 1) do_tx_we(p, 8'($urandom));
            if (m_rx_full[p] && ($urandom_range(0, 1) == 1)) do_rx_rd(p);
            frame_start(p);
            for (int k = 0; k < nb; k++) begin
                send_byte(p, 8'($urandom), got, exp);
                vectors++;
                if (got !== exp) begin miscompares++; $display("FAIL rnd_read it%0d p%0d: got %h exp %h", it, p, got, exp); end
            end
            frame_end(p);
            vectors += 5;
            if (rx_data[p] !== m_rx_data[p])  begin miscompares++; $display("FAIL rnd_rx it%0d p%0d: got %h exp %h", it, p, rx_data[p], m_rx_data[p]); end
            if (rx_full[p] !== m_rx_full[p])  begin miscompares++; $display("FAIL rnd_full it%0d p%0d: got %b exp %b", it, p, rx_full[p], m_rx_full[p]); end
            if (tx_empty[p] !== !m_tx_full[p]) begin miscompares++; $display("FAIL rnd_tx_empty it%0d p%0d: got %b exp %b", it, p, tx_empty[p], !m_tx_full[p]); end
            if (under_cnt[p] !== m_under[p])  begin miscompares++; $display("FAIL rnd_underrun it%0d p%0d: got %0d exp %0d", it, p, under_cnt[p], m_under[p]); end
            if (over_cnt[p] !== m_over[p])    begin miscompares++; $display("FAIL rnd_overrun it%0d p%0d: got %0d exp %0d", it, p, over_cnt[p], m_over[p]); end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        for (int k = 0; k < 2; k++) begin
            under_cnt[k] = 0; over_cnt[k] = 0; m_under[k] = 0; m_over[k] = 0;
            tx_data[k] = 8'h00;
        end
        model_reset();
        n_reset = 1'b0;
        cs = 2'b11; sck = 2'b10; mosi = 2'b00; tx_we = 2'b00; rx_rd = 2'b00;
        wait_clks(4);
        n_reset = 1'b1;
        wait_clks(4);
        test_reset();
        test_mode0_basic();
        test_back_to_back();
        test_partial();
        test_underrun_overrun();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
